// File: rtl/io_pkg.sv
// Shared front-panel constants: hex glyph table and all-off levels, all active-low.
// Pure constants; no latency or flow control involved.
package io_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Segment order is {g,f,e,d,c,b,a}; a zero bit lights the segment.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment glyph lookup.
// Purely combinational (zero latency); no flow control.
module hex_to_seg7
  import io_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nib];

endmodule

// File: rtl/out_display_driver.sv
// Captures OUT port writes and scans them as hex digits on a common-anode display.
// Capture in 1 cycle with a 1-cycle ack; display outputs lag the scan state by 1 cycle; never stalls the writer.
module out_display_driver
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] OUT_DATA,
  input  logic        OUT_WE,
  output logic        OUT_ACK,
  output logic [31:0] SHOWN,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int              PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_MAX   = 3'(DIGITS - 1);
  localparam logic [31:0]     VAL_MASK  = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                        : 32'((64'd1 << (4 * DIGITS)) - 64'd1);

  logic [PW-1:0] presc_q;
  logic          tick;
  scan_state_t   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shown_q;
  logic          ack_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [31:0]   upper_val;
  logic          blank;

  assign tick = (presc_q == PRESC_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Capture is independent of the scan: every strobe is taken, last one wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shown_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= OUT_WE;
      if (OUT_WE) begin
        shown_q <= OUT_DATA;
      end
    end
  end

  assign nibble    = 4'(shown_q >> {idx_q, 2'b00});
  assign upper_val = (shown_q & VAL_MASK) >> {idx_q, 2'b00};
  assign blank     = (BLANK_LZ != 0) && (idx_q != 3'd0) && (upper_val == 32'd0);

  hex_to_seg7 u_hex_to_seg7 (
    .nib (nibble),
    .seg (glyph)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          idx_d   = 3'd0;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end
        // A blanked digit keeps its anode driven so scan brightness stays uniform.
        an_d[idx_q] = 1'b0;
        seg_d       = blank ? SEG_OFF : glyph;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign OUT_ACK = ack_q;
  assign SHOWN   = shown_q;
  assign AN      = an_q;
  assign SEG     = seg_q;
  assign DP      = 1'b1;

endmodule

// File: tb/tb_out_display_driver.sv
// Drives three differently-configured display drivers with shared stimulus and
// compares every output against an arithmetic model of the scan timeline.
module tb_out_display_driver;

  localparam int NI = 3;
  localparam int SD [NI] = '{4, 4, 3};
  localparam int DG [NI] = '{8, 8, 4};
  localparam int BL [NI] = '{1, 0, 1};
  localparam logic [6:0] GLYPH_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] data = 32'd0;

  logic [NI-1:0]       ack_o;
  logic [NI-1:0][31:0] shown_o;
  logic [NI-1:0][7:0]  an_o;
  logic [NI-1:0][6:0]  seg_o;
  logic [NI-1:0]       dp_o;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned n_edge = 0;
  logic [31:0] shown_m = 32'd0;
  logic [31:0] prev_m = 32'd0;

  always #5 clk = ~clk;

  out_display_driver #(.SCAN_DIV(4), .DIGITS(8), .BLANK_LZ(1)) dut_a (
    .CLK(clk), .RST(rst), .OUT_DATA(data), .OUT_WE(we), .OUT_ACK(ack_o[0]),
    .SHOWN(shown_o[0]), .AN(an_o[0]), .SEG(seg_o[0]), .DP(dp_o[0])
  );
  out_display_driver #(.SCAN_DIV(4), .DIGITS(8), .BLANK_LZ(0)) dut_b (
    .CLK(clk), .RST(rst), .OUT_DATA(data), .OUT_WE(we), .OUT_ACK(ack_o[1]),
    .SHOWN(shown_o[1]), .AN(an_o[1]), .SEG(seg_o[1]), .DP(dp_o[1])
  );
  out_display_driver #(.SCAN_DIV(3), .DIGITS(4), .BLANK_LZ(1)) dut_c (
    .CLK(clk), .RST(rst), .OUT_DATA(data), .OUT_WE(we), .OUT_ACK(ack_o[2]),
    .SHOWN(shown_o[2]), .AN(an_o[2]), .SEG(seg_o[2]), .DP(dp_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, n_edge, got, exp);
    end
  endtask

  function automatic logic [31:0] lo_mask(input int d);
    return (d >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * d)) - 32'h1);
  endfunction

  // Display after edge n reflects the scan position and value as they stood after edge n-1.
  task automatic check_all(input logic exp_ack);
    int unsigned ticks, idx;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic [31:0] rest;
    logic [3:0]  nib;
    for (int i = 0; i < NI; i++) begin
      ticks = (n_edge - 1) / SD[i];
      if (ticks == 0) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end else begin
        idx     = (ticks - 1) % DG[i];
        exp_an  = ~(8'h01 << idx);
        nib     = 4'((prev_m >> (4 * idx)) & 32'hF);
        rest    = (prev_m & lo_mask(DG[i])) >> (4 * idx);
        exp_seg = (BL[i] != 0 && idx > 0 && rest == 32'd0) ? 7'h7F : GLYPH_REF[nib];
      end
      check($sformatf("ack%0d", i), 32'(ack_o[i]), 32'(exp_ack));
      check($sformatf("shown%0d", i), shown_o[i], shown_m);
      check($sformatf("an%0d", i), 32'(an_o[i]), 32'(exp_an));
      check($sformatf("seg%0d", i), 32'(seg_o[i]), 32'(exp_seg));
      check($sformatf("dp%0d", i), 32'(dp_o[i]), 32'd1);
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_an%0d", i), 32'(an_o[i]), 32'hFF);
      check($sformatf("rst_seg%0d", i), 32'(seg_o[i]), 32'h7F);
      check($sformatf("rst_shown%0d", i), shown_o[i], 32'd0);
      check($sformatf("rst_ack%0d", i), 32'(ack_o[i]), 32'd0);
      check($sformatf("rst_dp%0d", i), 32'(dp_o[i]), 32'd1);
    end
  endtask

  task automatic step(input logic w, input logic [31:0] d);
    we   = w;
    data = d;
    @(posedge clk);
    #1;
    n_edge++;
    prev_m = shown_m;
    if (w) shown_m = d;
    we   = 1'b0;
    data = 32'd0;
    check_all(w);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 32'd0);
  endtask

  // Asynchronous reset asserted between edges, observed before any further edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    #2;
    rst     = 1'b0;
    n_edge  = 0;
    shown_m = 32'd0;
    prev_m  = 32'd0;
  endtask

  initial begin
    logic        w;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    step(1'b1, 32'h1234_ABCD);
    idle(8 * 4 + 6);

    step(1'b1, 32'h0000_0050);
    idle(40);
    step(1'b1, 32'h0000_0000);
    idle(40);

    // Writes landing on the tick edge of the SCAN_DIV=4 instances.
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 32'h0);
      for (int k = 0; k < 4 && ((n_edge + 1) % 4) != 0; k++) step(1'b0, 32'd0);
      step(1'b1, 32'hFFFF_FFFF);
      idle(9);
    end

    step(1'b1, 32'd1);
    step(1'b1, 32'd2);
    step(1'b1, 32'd3);
    idle(6);

    step(1'b1, 32'hFFFF_1234);
    idle(30);

    step(1'b1, 32'hDEAD_BEEF);
    mid_reset();

    for (int it = 0; it < 700; it++) begin
      w = ($urandom_range(0, 7) == 0);
      d = $urandom & lo_mask($urandom_range(0, 8));
      step(w, d);
      if (it == 350) begin
        step(1'b1, 32'h0BAD_F00D);
        mid_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
